// File: rtl/pipeline_stall_controller_if.sv
// Request/control bundle between the hazard, branch, trap and memory sources
// and the central pipeline stall controller.
interface pipeline_stall_controller_if #(
  parameter int CNT_W = 32
);
  logic             hazard_stall;
  logic             branch_flush;
  logic             trap_flush;
  logic             imem_ready;
  logic             dmem_req;
  logic             dmem_ready;
  logic             mc_start;
  logic             mc_done;

  logic             pc_en;
  logic             if_en;
  logic             id_en;
  logic             ex_en;
  logic             mem_en;
  logic             wb_en;
  logic             id_flush;
  logic             ex_flush;
  logic             mem_flush;
  logic             trap_taken;
  logic             mc_kill;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output hazard_stall, branch_flush, trap_flush, imem_ready,
           dmem_req, dmem_ready, mc_start, mc_done,
    input  pc_en, if_en, id_en, ex_en, mem_en, wb_en,
           id_flush, ex_flush, mem_flush, trap_taken, mc_kill, stall_cnt
  );

  modport slave (
    input  hazard_stall, branch_flush, trap_flush, imem_ready,
           dmem_req, dmem_ready, mc_start, mc_done,
    output pc_en, if_en, id_en, ex_en, mem_en, wb_en,
           id_flush, ex_flush, mem_flush, trap_taken, mc_kill, stall_cnt
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush control for the five-stage pipeline: wait states for
// data memory and multi-cycle ops, deferred traps, and a stall-cycle counter.
module pipeline_stall_controller #(
  parameter int CNT_W = 32
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  pipeline_stall_controller_if.slave    pipe
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DMEM_WAIT = 2'd1,
    MC_WAIT   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_pend_trap;
  logic             w_pend_trap_next;
  logic [CNT_W-1:0] r_stall_cnt;

  // w_en = {pc, if, id, ex, mem, wb}; w_flush = {id, ex, mem}
  logic [5:0]       w_en;
  logic [2:0]       w_flush;
  logic             w_trap_taken;
  logic             w_mc_kill;
  logic             w_trap_any;
  logic             w_dmem_hold;
  logic             w_mc_hold;

  assign w_trap_any  = pipe.trap_flush || r_pend_trap;
  // The MEM access blocks only when no multi-cycle op owns the pipe.
  assign w_dmem_hold = !pipe.dmem_ready &&
                       ((r_state == DMEM_WAIT) || (r_state == RUN && pipe.dmem_req));
  assign w_mc_hold   = !pipe.mc_done && ((r_state == MC_WAIT) || pipe.mc_start);

  always_comb begin
    w_en             = 6'b111111;
    w_flush          = 3'b000;
    w_trap_taken     = 1'b0;
    w_mc_kill        = 1'b0;
    w_state_next     = r_state;
    w_pend_trap_next = r_pend_trap;

    if (!reset_i) begin
      w_en    = 6'b000000;
      w_flush = 3'b111;
    end else if (w_dmem_hold) begin
      w_en         = 6'b000000;
      w_state_next = DMEM_WAIT;
      if (pipe.trap_flush) begin
        w_pend_trap_next = 1'b1;
      end
    end else if (w_trap_any) begin
      w_flush          = 3'b111;
      w_trap_taken     = 1'b1;
      w_mc_kill        = (r_state == MC_WAIT);
      w_pend_trap_next = 1'b0;
      w_state_next     = RUN;
    end else if (w_mc_hold) begin
      w_en         = 6'b000011;
      w_flush      = 3'b001;
      w_state_next = MC_WAIT;
    end else begin
      w_state_next = RUN;
      // A taken branch makes the ID instruction wrong-path, so it outranks
      // the load-use stall and the fetch miss.
      if (pipe.branch_flush) begin
        w_flush = 3'b110;
      end else if (pipe.hazard_stall) begin
        w_en    = 6'b000111;
        w_flush = 3'b010;
      end else if (!pipe.imem_ready) begin
        w_en    = 6'b001111;
        w_flush = 3'b100;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_state     <= RUN;
      r_pend_trap <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_pend_trap <= w_pend_trap_next;
      if (!w_en[5] && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign {pipe.pc_en, pipe.if_en, pipe.id_en,
          pipe.ex_en, pipe.mem_en, pipe.wb_en} = w_en;
  assign {pipe.id_flush, pipe.ex_flush, pipe.mem_flush} = w_flush;
  assign pipe.trap_taken = w_trap_taken;
  assign pipe.mc_kill    = w_mc_kill;
  assign pipe.stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Randomized and directed check of pipeline_stall_controller against a
// behavioural model of the stall/flush priority rules.
module tb_pipeline_stall_controller;

  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;

  pipeline_stall_controller_if #(.CNT_W(32)) bus ();
  pipeline_stall_controller_if #(.CNT_W(4))  bus4 ();

  pipeline_stall_controller #(.CNT_W(32)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .pipe    (bus)
  );

  pipeline_stall_controller #(.CNT_W(4)) dut4 (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .pipe    (bus4)
  );

  // Input vector order: {rst, haz, br, trap, imem, dreq, drdy, mcs, mcd}
  localparam bit [8:0] M_RST = 9'b100000000;
  localparam bit [8:0] M_HAZ = 9'b010000000;
  localparam bit [8:0] M_BR  = 9'b001000000;
  localparam bit [8:0] M_TR  = 9'b000100000;
  localparam bit [8:0] M_IM  = 9'b000010000;
  localparam bit [8:0] M_DQ  = 9'b000001000;
  localparam bit [8:0] M_DR  = 9'b000000100;
  localparam bit [8:0] M_MS  = 9'b000000010;
  localparam bit [8:0] M_MD  = 9'b000000001;
  localparam bit [8:0] NEUT  = M_RST | M_IM;

  // Output vector: {pc,if,id,ex,mem,wb, id_f,ex_f,mem_f, trap_taken, mc_kill}
  localparam bit [10:0] V_NONE = 11'b111111_000_00;
  localparam bit [10:0] V_RST  = 11'b000000_111_00;
  localparam bit [10:0] V_FRZ  = 11'b000000_000_00;
  localparam bit [10:0] V_TRAP = 11'b111111_111_10;
  localparam bit [10:0] V_KILL = 11'b111111_111_11;
  localparam bit [10:0] V_MC   = 11'b000011_001_00;
  localparam bit [10:0] V_BR   = 11'b111111_110_00;
  localparam bit [10:0] V_HAZ  = 11'b000111_010_00;
  localparam bit [10:0] V_IM   = 11'b001111_100_00;

  typedef enum int {A_RESET, A_FREEZE, A_TRAP, A_KILL, A_MC,
                    A_BRANCH, A_HAZARD, A_IMISS, A_NONE} act_t;

  bit [8:0] s_in = 9'b0;

  // Model state: which kind of wait the pipeline sits in, deferred trap, count.
  bit     m_in_dmem = 1'b0;
  bit     m_in_mc   = 1'b0;
  bit     m_pend    = 1'b0;
  longint m_cnt     = 0;

  bit        lit_vec_v = 1'b0;
  bit [10:0] lit_vec   = '0;
  int        lit_cnt   = -1;
  int        lit_cnt4  = -1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic apply_inputs(input bit [8:0] in);
    s_in    = in;
    reset_i = in[8];
    bus.hazard_stall  = in[7]; bus4.hazard_stall  = in[7];
    bus.branch_flush  = in[6]; bus4.branch_flush  = in[6];
    bus.trap_flush    = in[5]; bus4.trap_flush    = in[5];
    bus.imem_ready    = in[4]; bus4.imem_ready    = in[4];
    bus.dmem_req      = in[3]; bus4.dmem_req      = in[3];
    bus.dmem_ready    = in[2]; bus4.dmem_ready    = in[2];
    bus.mc_start      = in[1]; bus4.mc_start      = in[1];
    bus.mc_done       = in[0]; bus4.mc_done       = in[0];
  endtask

  function automatic act_t lower_rules(input bit [8:0] in);
    if (in[6])       return A_BRANCH;
    else if (in[7])  return A_HAZARD;
    else if (!in[4]) return A_IMISS;
    else             return A_NONE;
  endfunction

  function automatic act_t decide(input bit [8:0] in);
    bit trap_any;
    trap_any = in[5] || m_pend;
    if (!in[8]) return A_RESET;
    if (m_in_mc) begin
      if (trap_any) return A_KILL;
      if (!in[0])   return A_MC;
      return lower_rules(in);
    end
    if (!in[2] && (m_in_dmem || in[3])) return A_FREEZE;
    if (trap_any)                       return A_TRAP;
    if (in[1] && !in[0])                return A_MC;
    return lower_rules(in);
  endfunction

  function automatic bit [10:0] act_vec(input act_t a);
    case (a)
      A_RESET:  return V_RST;
      A_FREEZE: return V_FRZ;
      A_TRAP:   return V_TRAP;
      A_KILL:   return V_KILL;
      A_MC:     return V_MC;
      A_BRANCH: return V_BR;
      A_HAZARD: return V_HAZ;
      A_IMISS:  return V_IM;
      default:  return V_NONE;
    endcase
  endfunction

  task automatic check_vec(input string name, input bit [10:0] got, input bit [10:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b want %b (in=%b)", name, $time, got, exp, s_in);
    end
  endtask

  task automatic check_cnt(input string name, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d want %0d", name, $time, got, exp);
    end
  endtask

  // Single compare process: every negedge, DUT outputs vs model (and literals).
  always @(negedge clk_i) begin
    act_t      a;
    bit [10:0] exp, got, got4;
    longint    exp4;
    a    = decide(s_in);
    exp  = act_vec(a);
    got  = {bus.pc_en, bus.if_en, bus.id_en, bus.ex_en, bus.mem_en, bus.wb_en,
            bus.id_flush, bus.ex_flush, bus.mem_flush, bus.trap_taken, bus.mc_kill};
    got4 = {bus4.pc_en, bus4.if_en, bus4.id_en, bus4.ex_en, bus4.mem_en, bus4.wb_en,
            bus4.id_flush, bus4.ex_flush, bus4.mem_flush, bus4.trap_taken, bus4.mc_kill};
    exp4 = (m_cnt > 15) ? 64'd15 : m_cnt;

    check_vec("ctrl", got, exp);
    check_vec("ctrl_w4", got4, exp);
    check_cnt("stall_cnt", longint'(bus.stall_cnt), m_cnt);
    check_cnt("stall_cnt_w4", longint'(bus4.stall_cnt), exp4);
    if (lit_vec_v)     check_vec("lit_ctrl", got, lit_vec);
    if (lit_cnt >= 0)  check_cnt("lit_cnt", longint'(bus.stall_cnt), longint'(lit_cnt));
    if (lit_cnt4 >= 0) check_cnt("lit_cnt_w4", longint'(bus4.stall_cnt), longint'(lit_cnt4));

    // Advance the model to what the next rising edge produces.
    if (a == A_RESET) begin
      m_in_dmem = 1'b0;
      m_in_mc   = 1'b0;
      m_pend    = 1'b0;
      m_cnt     = 0;
    end else begin
      if (exp[10] == 1'b0) m_cnt = m_cnt + 1;
      m_pend    = (a == A_FREEZE) ? (m_pend || s_in[5])
                                  : (m_pend && a != A_TRAP && a != A_KILL);
      m_in_dmem = (a == A_FREEZE);
      m_in_mc   = (a == A_MC);
    end
  end

  task automatic dstep(input bit [8:0] in, input bit [10:0] v, input int c, input int c4);
    apply_inputs(in);
    lit_vec_v = 1'b1;
    lit_vec   = v;
    lit_cnt   = c;
    lit_cnt4  = c4;
    @(posedge clk_i);
    #1;
    lit_vec_v = 1'b0;
    lit_cnt   = -1;
    lit_cnt4  = -1;
  endtask

  task automatic rstep(input bit [8:0] in);
    apply_inputs(in);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    bit [8:0] r;
    apply_inputs(NEUT & ~M_RST);
    @(posedge clk_i);
    #1;

    dstep(NEUT & ~M_RST, V_RST, 0, 0);
    dstep(NEUT & ~M_RST, V_RST, 0, 0);
    dstep(NEUT, V_NONE, 0, -1);

    // Load-use stall for one cycle
    dstep(NEUT | M_HAZ, V_HAZ, 0, -1);
    dstep(NEUT, V_NONE, 1, -1);

    // Branch beats hazard and fetch miss
    dstep((NEUT | M_BR | M_HAZ) & ~M_IM, V_BR, 1, -1);
    dstep(NEUT, V_NONE, 1, -1);

    // Data-memory wait with a trap pulse in its second cycle
    dstep(NEUT | M_DQ, V_FRZ, 1, -1);
    dstep(NEUT | M_DQ | M_TR, V_FRZ, 2, -1);
    dstep(NEUT | M_DQ, V_FRZ, 3, -1);
    dstep(NEUT | M_DQ | M_DR, V_TRAP, 4, -1);
    dstep(NEUT, V_NONE, 4, -1);

    // Multi-cycle op completing in its fourth cycle
    dstep(NEUT | M_MS, V_MC, 4, -1);
    dstep(NEUT | M_MS, V_MC, 5, -1);
    dstep(NEUT | M_MS, V_MC, 6, -1);
    dstep(NEUT | M_MS | M_MD, V_NONE, 7, -1);
    dstep(NEUT, V_NONE, 7, -1);

    // Trap while waiting on a multi-cycle op
    dstep(NEUT | M_MS, V_MC, 7, -1);
    dstep(NEUT | M_MS | M_TR, V_KILL, 8, -1);
    dstep(NEUT, V_NONE, 8, -1);

    // Reset in the middle of a data wait holding a deferred trap
    dstep(NEUT | M_DQ | M_TR, V_FRZ, 8, -1);
    dstep(NEUT | M_DQ, V_FRZ, 9, -1);
    dstep((NEUT | M_DQ) & ~M_RST, V_RST, 10, -1);
    dstep(NEUT, V_NONE, 0, 0);

    // 20 frozen cycles: the 4-bit counter pins at 15
    for (int i = 0; i < 20; i++) rstep(NEUT | M_DQ);
    dstep(NEUT | M_DQ | M_DR, V_NONE, 20, 15);

    for (int i = 0; i < 4000; i++) begin
      r = '0;
      r[8] = ($urandom_range(0, 63) != 0);
      r[7] = ($urandom_range(0, 3) == 0);
      r[6] = ($urandom_range(0, 5) == 0);
      r[5] = ($urandom_range(0, 11) == 0);
      r[4] = ($urandom_range(0, 4) != 0);
      r[3] = ($urandom_range(0, 2) == 0);
      r[2] = ($urandom_range(0, 1) == 0);
      r[1] = ($urandom_range(0, 3) == 0);
      r[0] = ($urandom_range(0, 2) == 0);
      rstep(r);
    end

    rstep(NEUT);
    rstep(NEUT);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Central pipeline control for the five-stage core: consumes the stall and flush requests raised by the hazard logic, branch unit, trap logic, memory handshakes and multi-cycle execute units, and drives the per-stage register enables and bubble-insertion (flush) controls. It owns the wait-state machine for data-memory and multi-cycle (divide/FP) operations, latches traps that arrive while the pipeline is frozen, and keeps a stall-cycle performance counter.

## Interface
- CNT_W, 32, width of stall_cnt
- clk_i  input  1  clock; all state updates on rising edge
- reset_i  input  1  synchronous, active-low reset
- hazard_stall  input  1  load-use hazard: instruction in ID depends on load in EX
- branch_flush  input  1  taken branch/jump resolved in EX; PC redirect this cycle
- trap_flush  input  1  exception/interrupt redirect request (may be a one-cycle pulse)
- imem_ready  input  1  fetch data valid this cycle
- dmem_req  input  1  MEM stage holds a load/store
- dmem_ready  input  1  data memory completes the MEM access this cycle
- mc_start  input  1  EX holds a multi-cycle op (div/FP)
- mc_done  input  1  multi-cycle unit result valid this cycle
- pc_en, if_en, id_en, ex_en, mem_en, wb_en  output  1 each  stage register enables
- id_flush, ex_flush, mem_flush  output  1 each  load a bubble into that stage register (valid only with its enable)
- trap_taken  output  1  trap redirect applied this cycle
- mc_kill  output  1  abort the in-flight multi-cycle op
- stall_cnt  output  CNT_W  cycles with pc_en low since reset, saturating

## Operation
- States: RUN, DMEM_WAIT, MC_WAIT. Registered: state, pend_trap, stall_cnt. All other outputs combinational from state, pend_trap and inputs.
- Default (no request): all enables 1, all flushes 0, trap_taken 0, mc_kill 0.
- RUN priority, first match wins:
  - dmem_req && !dmem_ready: all enables 0 -> DMEM_WAIT; trap_flush sets pend_trap.
  - trap_flush || pend_trap: all enables 1, id/ex/mem_flush 1, trap_taken 1, pend_trap cleared.
  - mc_start && !mc_done: pc/if/id/ex_en 0; mem_en 1, mem_flush 1, wb_en 1 -> MC_WAIT.
  - branch_flush: all enables 1, id_flush 1, ex_flush 1.
  - hazard_stall: pc/if/id_en 0; ex_en 1, ex_flush 1; mem/wb_en 1.
  - !imem_ready: pc_en 0, if_en 0; id_en 1, id_flush 1; rest 1.
- DMEM_WAIT: dmem_ready low -> all enables 0, trap_flush sets pend_trap. dmem_ready high -> apply RUN rules with dmem condition treated satisfied; next state per those rules.
- MC_WAIT: trap_flush or pend_trap -> mc_kill 1 and trap action as in RUN, -> RUN. Else mc_done low -> MC_WAIT outputs held (EX frozen, bubbles into MEM). mc_done high -> RUN rules with mc condition satisfied. dmem_req is don't-care (MEM holds bubbles).
- Branch beats hazard_stall and !imem_ready (ID instruction is wrong-path). hazard_stall beats !imem_ready.
- stall_cnt increments each cycle pc_en is 0 with reset_i high; holds at all-ones.

## Timing
- Reset: when reset_i is 0 at a rising edge, state <= RUN, pend_trap <= 0, stall_cnt <= 0. While reset_i is 0, outputs forced: all enables 0, id/ex/mem_flush 1, trap_taken 0, mc_kill 0.
- Zero-latency control: outputs respond combinationally in the same cycle as the request. State changes take effect the next cycle.
- Reset asserted mid-wait aborts it: no pending trap or wait state survives.
- A trap pulse arriving during DMEM_WAIT takes effect in the cycle dmem_ready is seen; it is never lost and is never applied twice.
- A multi-cycle op occupies MC_WAIT for N-1 cycles when mc_done arrives in cycle N after entry (mc_done in entry cycle: no MC_WAIT).

## Test plan
- Load-use: hazard_stall=1 one cycle in RUN -> pc/if/id_en=0, ex_flush=1, mem/wb_en=1; stall_cnt +1; next cycle all enables 1.
- Branch + hazard + imem miss same cycle -> pc_en=1, id_flush=ex_flush=1, no stall, stall_cnt unchanged.
- dmem_req=1, dmem_ready low 3 cycles, trap_flush pulse in 2nd -> all enables 0 for 3 cycles, then trap_taken=1 with id/ex/mem_flush=1 in the dmem_ready cycle only; stall_cnt +3.
- mc_start=1, mc_done after 4 cycles -> MC_WAIT: mem_flush=1, ex_en=0 each wait cycle; mc_done cycle all enables 1; back to RUN.
- trap_flush during MC_WAIT -> mc_kill=1, trap_taken=1 same cycle, state RUN next cycle.
- reset_i low during DMEM_WAIT with pend_trap set -> after release: RUN, stall_cnt=0, no trap_taken; stall_cnt saturates at 2^CNT_W-1 under a forced CNT_W=4 stall run of 20 cycles.
